code_lock_ctrl: RTL and testbench



---
 rtl/code_lock_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: collects CODE_LEN digits, checks against the stored code,
// drives unlock/alarm, locks out after MAX_FAIL misses, allows code change while open.
module code_lock_ctrl #(
    parameter int                    CODE_LEN     = 4,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
    parameter int                    MAX_FAIL     = 3,
    parameter int                    UNLOCK_CYC   = 1000,
    parameter int                    LOCKOUT_CYC  = 2000,
    parameter int                    TIMEOUT_CYC  = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_flag,
    input  logic [3:0] key_value,
    output logic       unlock,
    output logic       alarm,
    output logic       err,
    output logic       ok,
    output logic [2:0] digit_cnt
);

    localparam int BW    = 4 * CODE_LEN;
    localparam int CW    = $clog2(CODE_LEN + 1);
    localparam int FW    = $clog2(MAX_FAIL + 1);
    localparam int MAX_UL = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int MAXC  = (MAX_UL > TIMEOUT_CYC) ? MAX_UL : TIMEOUT_CYC;
    localparam int TW    = $clog2(MAXC + 1);

    // Timer counts down to zero; expiry is the edge on which it reads zero.
    localparam logic [TW-1:0] UNL_LD = TW'(UNLOCK_CYC - 1);
    localparam logic [TW-1:0] LCK_LD = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] FULL   = CW'(CODE_LEN);
    localparam logic [FW-1:0] FMAX   = FW'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_SET, S_LOCKOUT
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  buf_q, buf_d;
    logic [BW-1:0]  code_q, code_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [FW-1:0]  fail_q, fail_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           unlock_q, unlock_d;
    logic           alarm_q, alarm_d;
    logic           err_q, err_d;
    logic           ok_q, ok_d;

    logic           key_ok, is_digit, is_clr, is_ent;
    logic [BW-1:0]  buf_shift;
    logic [FW-1:0]  fail_inc;

    assign key_ok    = key_flag && (key_value <= 4'd11);
    assign is_digit  = key_flag && (key_value <= 4'd9);
    assign is_clr    = key_flag && (key_value == 4'd10);
    assign is_ent    = key_flag && (key_value == 4'd11);
    assign buf_shift = (buf_q << 4) | BW'(key_value);
    assign fail_inc  = fail_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        tmr_d    = tmr_q;
        unlock_d = unlock_q;
        alarm_d  = alarm_q;
        err_d    = 1'b0;
        ok_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_digit) begin
                    buf_d   = buf_shift;
                    cnt_d   = CW'(1);
                    tmr_d   = TO_LD;
                    state_d = S_ENTRY;
                end
            end

            // ENTRY and SET share digit collection and the idle timeout;
            // a key arriving on the timeout edge takes priority.
            S_ENTRY, S_SET: begin
                if (key_ok) begin
                    tmr_d = TO_LD;
                    if (is_digit) begin
                        if (cnt_q < FULL) begin
                            buf_d = buf_shift;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (is_clr) begin
                        buf_d    = '0;
                        cnt_d    = '0;
                        unlock_d = 1'b0;
                        state_d  = S_IDLE;
                    end else if (state_q == S_ENTRY) begin
                        state_d = S_CHECK;
                    end else if (cnt_q == FULL) begin
                        code_d   = buf_q;
                        ok_d     = 1'b1;
                        unlock_d = 1'b0;
                        buf_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_IDLE;
                    end else begin
                        err_d = 1'b1;
                        buf_d = '0;
                        cnt_d = '0;
                    end
                end else if (tmr_q == '0) begin
                    buf_d    = '0;
                    cnt_d    = '0;
                    unlock_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end

            S_CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (cnt_q == FULL && buf_q == code_q) begin
                    fail_d   = '0;
                    unlock_d = 1'b1;
                    tmr_d    = UNL_LD;
                    state_d  = S_OPEN;
                end else begin
                    err_d  = 1'b1;
                    fail_d = fail_inc;
                    if (fail_inc == FMAX) begin
                        alarm_d = 1'b1;
                        tmr_d   = LCK_LD;
                        state_d = S_LOCKOUT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            // Expiry beats a key on the same edge.
            S_OPEN: begin
                if (tmr_q == '0) begin
                    unlock_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (is_clr) begin
                    unlock_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (is_ent) begin
                    tmr_d   = TO_LD;
                    state_d = S_SET;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end

            S_LOCKOUT: begin
                if (tmr_q == '0) begin
                    alarm_d = 1'b0;
                    fail_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            buf_q    <= '0;
            code_q   <= DEFAULT_CODE;
            cnt_q    <= '0;
            fail_q   <= '0;
            tmr_q    <= '0;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
            err_q    <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            tmr_q    <= tmr_d;
            unlock_q <= unlock_d;
            alarm_q  <= alarm_d;
            err_q    <= err_d;
            ok_q     <= ok_d;
        end
    end

    assign unlock    = unlock_q;
    assign alarm     = alarm_q;
    assign err       = err_q;
    assign ok        = ok_q;
    assign digit_cnt = 3'(cnt_q);

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: directed and random key sequences compared every
// cycle against a deadline/queue based model of the lock behaviour.
module tb_code_lock_ctrl;

    localparam int          CODE_LEN    = 4;
    localparam logic [15:0] DEF_CODE    = 16'h1234;
    localparam int          MAX_FAIL    = 3;
    localparam int          UNLOCK_CYC  = 1000;
    localparam int          LOCKOUT_CYC = 2000;
    localparam int          TIMEOUT_CYC = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_flag = 1'b0;
    logic [3:0] key_value = 4'd0;
    logic       unlock, alarm, err, ok;
    logic [2:0] digit_cnt;

    code_lock_ctrl #(
        .CODE_LEN(CODE_LEN), .DEFAULT_CODE(DEF_CODE), .MAX_FAIL(MAX_FAIL),
        .UNLOCK_CYC(UNLOCK_CYC), .LOCKOUT_CYC(LOCKOUT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_flag(key_flag), .key_value(key_value),
        .unlock(unlock), .alarm(alarm), .err(err), .ok(ok), .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    int    vectors = 0;
    int    miscompares = 0;
    string tag = "init";

    // Model: typed digits in a queue, open/lockout/timeout as absolute edge deadlines.
    int          digs[$];
    bit          m_set, m_unl, m_alm, m_chk, m_err, m_ok;
    int          open_dl, lock_dl, last_key, fails, e;
    logic [15:0] m_code;

    function automatic logic [15:0] digs_val();
        logic [15:0] v = 16'h0;
        foreach (digs[i]) v = (v << 4) | 16'(digs[i]);
        return v;
    endfunction

    task automatic model_reset();
        digs.delete();
        m_set = 0; m_unl = 0; m_alm = 0; m_chk = 0; m_err = 0; m_ok = 0;
        open_dl = 0; lock_dl = 0; last_key = 0; fails = 0; e = 0;
        m_code = DEF_CODE;
    endtask

    task automatic model_step(input bit kf, input logic [3:0] kv);
        bit key;
        e++;
        m_err = 0;
        m_ok  = 0;
        key   = kf && (kv <= 4'd11);
        if (m_chk) begin
            m_chk = 0;
            if (digs.size() == CODE_LEN && digs_val() == m_code) begin
                fails = 0; m_unl = 1; open_dl = e + UNLOCK_CYC;
            end else begin
                m_err = 1; fails++;
                if (fails == MAX_FAIL) begin
                    m_alm = 1; lock_dl = e + LOCKOUT_CYC;
                end
            end
            digs.delete();
        end else if (m_alm) begin
            if (e == lock_dl) begin m_alm = 0; fails = 0; end
        end else if (m_unl && !m_set) begin
            if (e == open_dl) m_unl = 0;
            else if (key && kv == 4'd10) m_unl = 0;
            else if (key && kv == 4'd11) begin m_set = 1; digs.delete(); last_key = e; end
        end else if (m_set || digs.size() > 0) begin
            if (key) begin
                last_key = e;
                if (kv <= 4'd9) begin
                    if (digs.size() < CODE_LEN) digs.push_back(int'(kv));
                end else if (kv == 4'd10) begin
                    digs.delete();
                    if (m_set) begin m_set = 0; m_unl = 0; end
                end else if (!m_set) begin
                    m_chk = 1;
                end else begin
                    if (digs.size() == CODE_LEN) begin
                        m_code = digs_val(); m_ok = 1; m_set = 0; m_unl = 0;
                    end else begin
                        m_err = 1;
                    end
                    digs.delete();
                end
            end else if (e - last_key == TIMEOUT_CYC) begin
                digs.delete();
                if (m_set) begin m_set = 0; m_unl = 0; end
            end
        end else if (key && kv <= 4'd9) begin
            digs.push_back(int'(kv));
            last_key = e;
        end
    endtask

    task automatic check();
        logic [6:0] got, exp;
        got = {unlock, alarm, err, ok, digit_cnt};
        exp = {m_unl, m_alm, m_err, m_ok, 3'(digs.size())};
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s edge %0d: got ul/al/er/ok/cnt=%b want %b", tag, e, got, exp);
        end
    endtask

    task automatic tick(input bit kf, input logic [3:0] kv);
        key_flag  = kf;
        key_value = kf ? kv : 4'($urandom);
        @(posedge clk);
        model_step(kf, kv);
        #1;
        check();
        key_flag = 1'b0;
    endtask

    task automatic press(input logic [3:0] kv);
        tick(1'b1, kv);
        repeat ($urandom_range(1, 3)) tick(1'b0, 4'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 4'd0);
    endtask

    task automatic do_reset();
        logic [6:0] got;
        rst_n = 1'b0;
        key_flag = 1'b0;
        model_reset();
        #2;
        got = {unlock, alarm, err, ok, digit_cnt};
        vectors++;
        assert (got === 7'b0) else begin
            miscompares++;
            $error("FAIL %s reset_async: got %b want %b", tag, got, 7'b0);
        end
        @(posedge clk);
        #1;
        check();
        rst_n = 1'b1;
    endtask

    task automatic enter_code(input logic [15:0] c, input bit hash);
        for (int i = 3; i >= 0; i--) press(c[4*i +: 4]);
        if (hash) press(4'd11);
    endtask

    initial begin
        model_reset();
        #3;
        tag = "reset";
        do_reset();

        tag = "correct";
        enter_code(16'h1234, 1);
        idle(UNLOCK_CYC + 5);

        tag = "lockout";
        repeat (3) enter_code(16'h1235, 1);
        for (int i = 0; i < 20; i++) press(4'($urandom));
        idle(LOCKOUT_CYC + 10);
        enter_code(16'h1234, 1);
        press(4'd10);

        tag = "change";
        enter_code(16'h1234, 1);
        press(4'd11);
        enter_code(16'h9876, 1);
        enter_code(16'h1234, 1);
        enter_code(16'h9876, 1);
        press(4'd10);

        tag = "reset2";
        do_reset();

        tag = "length";
        press(4'd1); press(4'd2); press(4'd11);
        enter_code(16'h1234, 0);
        press(4'd5); press(4'd11);
        press(4'd11);
        press(4'd5); press(4'd11);
        press(4'd10);

        tag = "clear";
        press(4'd1); press(4'd2); press(4'd10);
        enter_code(16'h1234, 1);
        press(4'd10);
        press(4'd1); press(4'd2);
        idle(TIMEOUT_CYC + 5);
        press(4'd3); press(4'd4); press(4'd11);

        tag = "rst_mid";
        enter_code(16'h1234, 1);
        press(4'd11);
        press(4'd9); press(4'd8);
        do_reset();
        enter_code(16'h1234, 1);
        press(4'd10);

        tag = "random";
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [3:0] kv;
            r = $urandom_range(0, 19);
            if (r < 10)      kv = 4'($urandom_range(1, 5));
            else if (r < 13) kv = 4'($urandom_range(0, 9));
            else if (r < 16) kv = 4'd11;
            else if (r < 18) kv = 4'd10;
            else             kv = 4'($urandom_range(12, 15));
            tick(1'b1, kv);
            repeat ($urandom_range(0, 3)) tick(1'b0, 4'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
